// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit_pkg : shared fetch FSM encoding, reset values, alignment.
// Revision: 1.0
// ============================================================================
package instr_fetch_unit_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE = 2'd0;
    localparam fetch_state_t ST_REQ  = 2'd1;
    localparam fetch_state_t ST_HOLD = 2'd2;

    localparam int unsigned INSTR_RESET_VAL = 0;
    localparam logic [1:0]  ALIGN_MASK      = 2'b00;

    function automatic logic is_aligned(input logic [1:0] lo);
        return lo == ALIGN_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_wait_timer.sv
`default_nettype none
// ============================================================================
// fetch_wait_timer : saturating wait-state counter with clear/enable/expired.
// Revision: 1.0
// ============================================================================
module fetch_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic Clock,
    input  logic Reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] c_SAT  = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge Clock) begin
        if (Reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_SAT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expired on the cycle the count has reached MAX_WAIT-1.
    assign o_expired = (r_count >= c_LAST);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : PC-to-instruction-memory fetch front end with handshake.
// Revision: 1.0
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PCin,
    input  logic              FetchEn,
    input  logic              Flush,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    input  logic              MemReady,
    input  logic [DATA_W-1:0] MemData,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] InstrAddr,
    output logic              InstrValid,
    input  logic              DecodeReady,
    output logic              Busy,
    output logic              Timeout,
    output logic              AddrErr
);
    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_read;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_addr;
    logic              r_instr_valid;
    logic              r_timeout;
    logic              r_addr_err;

    logic w_in_req;
    logic w_aligned;
    logic w_expired;

    assign w_in_req  = (r_state == ST_REQ);
    assign w_aligned = is_aligned(PCin[1:0]);

    // Held at zero outside REQ so every request starts its wait count fresh.
    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .Clock     (Clock),
        .Reset     (Reset),
        .i_clear   (!w_in_req),
        .i_enable  (w_in_req && !Flush && !MemReady),
        .o_expired (w_expired)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_mem_addr    <= '0;
            r_mem_read    <= 1'b0;
            r_instr       <= DATA_W'(INSTR_RESET_VAL);
            r_instr_addr  <= '0;
            r_instr_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_addr_err    <= 1'b0;
        end else begin
            r_timeout  <= 1'b0;
            r_addr_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (FetchEn && !Flush) begin
                        if (w_aligned) begin
                            r_mem_addr <= PCin;
                            r_mem_read <= 1'b1;
                            r_state    <= ST_REQ;
                        end else begin
                            r_addr_err <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (Flush) begin
                        r_mem_read <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (MemReady) begin
                        r_instr       <= MemData;
                        r_instr_addr  <= r_mem_addr;
                        r_instr_valid <= 1'b1;
                        r_mem_read    <= 1'b0;
                        r_state       <= ST_HOLD;
                    end else if (w_expired) begin
                        r_mem_read <= 1'b0;
                        r_timeout  <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (Flush) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (DecodeReady) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                        if (FetchEn) begin
                            if (w_aligned) begin
                                r_mem_addr <= PCin;
                                r_mem_read <= 1'b1;
                                r_state    <= ST_REQ;
                            end else begin
                                r_addr_err <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_mem_read    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign MemAddr    = r_mem_addr;
    assign MemRead    = r_mem_read;
    assign Instr      = r_instr;
    assign InstrAddr  = r_instr_addr;
    assign InstrValid = r_instr_valid;
    assign Busy       = w_in_req;
    assign Timeout    = r_timeout;
    assign AddrErr    = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_unit : directed self-checking bench for instr_fetch_unit.
// Revision: 1.0
// ============================================================================
module tb_instr_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] PCin;
    logic        FetchEn;
    logic        Flush;
    logic [31:0] MemAddr;
    logic        MemRead;
    logic        MemReady;
    logic [31:0] MemData;
    logic [31:0] Instr;
    logic [31:0] InstrAddr;
    logic        InstrValid;
    logic        DecodeReady;
    logic        Busy;
    logic        Timeout;
    logic        AddrErr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clock = ~Clock;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (15)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .PCin        (PCin),
        .FetchEn     (FetchEn),
        .Flush       (Flush),
        .MemAddr     (MemAddr),
        .MemRead     (MemRead),
        .MemReady    (MemReady),
        .MemData     (MemData),
        .Instr       (Instr),
        .InstrAddr   (InstrAddr),
        .InstrValid  (InstrValid),
        .DecodeReady (DecodeReady),
        .Busy        (Busy),
        .Timeout     (Timeout),
        .AddrErr     (AddrErr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns later, away from the edge.
    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; PCin = '0; FetchEn = 1'b0; Flush = 1'b0;
        MemReady = 1'b0; MemData = '0; DecodeReady = 1'b0;
        tick; tick;
        Reset = 1'b0;
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_instr", Instr, 32'd0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_flags", {30'd0, Timeout, AddrErr}, 32'd0);

        // Zero-wait fetch
        PCin = 32'h10; FetchEn = 1'b1;
        tick;
        FetchEn = 1'b0;
        chk("zw_memread", 32'(MemRead), 32'd1);
        chk("zw_memaddr", MemAddr, 32'h10);
        chk("zw_busy", 32'(Busy), 32'd1);
        MemReady = 1'b1; MemData = 32'h8C220004;
        tick;
        MemReady = 1'b0;
        chk("zw_memread_off", 32'(MemRead), 32'd0);
        chk("zw_valid", 32'(InstrValid), 32'd1);
        chk("zw_instr", Instr, 32'h8C220004);
        chk("zw_iaddr", InstrAddr, 32'h10);
        tick;
        chk("zw_hold_valid", 32'(InstrValid), 32'd1);
        chk("zw_hold_instr", Instr, 32'h8C220004);
        DecodeReady = 1'b1;
        tick;
        DecodeReady = 1'b0;
        chk("zw_consumed", 32'(InstrValid), 32'd0);
        chk("zw_idle", 32'(Busy), 32'd0);

        // Three wait states, ready on the fourth REQ cycle
        PCin = 32'h20; FetchEn = 1'b1;
        tick;
        FetchEn = 1'b0; PCin = 32'h99;
        for (int i = 0; i < 3; i++) begin
            chk("ws_memread", 32'(MemRead), 32'd1);
            chk("ws_memaddr", MemAddr, 32'h20);
            chk("ws_busy", 32'(Busy), 32'd1);
            chk("ws_novalid", 32'(InstrValid), 32'd0);
            tick;
        end
        chk("ws_memread4", 32'(MemRead), 32'd1);
        chk("ws_busy4", 32'(Busy), 32'd1);
        MemReady = 1'b1; MemData = 32'h12345678;
        tick;
        MemReady = 1'b0;
        chk("ws_valid", 32'(InstrValid), 32'd1);
        chk("ws_instr", Instr, 32'h12345678);
        chk("ws_iaddr", InstrAddr, 32'h20);
        chk("ws_memread_off", 32'(MemRead), 32'd0);

        // FetchEn without DecodeReady is ignored in HOLD
        PCin = 32'h40; FetchEn = 1'b1;
        tick;
        chk("hold_ignore_rd", 32'(MemRead), 32'd0);
        chk("hold_ignore_v", 32'(InstrValid), 32'd1);

        // Back-to-back fetch from HOLD
        DecodeReady = 1'b1; PCin = 32'h14;
        tick;
        DecodeReady = 1'b0; FetchEn = 1'b0;
        chk("b2b_valid", 32'(InstrValid), 32'd0);
        chk("b2b_memread", 32'(MemRead), 32'd1);
        chk("b2b_memaddr", MemAddr, 32'h14);
        chk("b2b_busy", 32'(Busy), 32'd1);

        // Flush takes priority over MemReady
        Flush = 1'b1; MemReady = 1'b1; MemData = 32'hDEADBEEF;
        tick;
        Flush = 1'b0; MemReady = 1'b0;
        chk("fl_busy", 32'(Busy), 32'd0);
        chk("fl_memread", 32'(MemRead), 32'd0);
        chk("fl_valid", 32'(InstrValid), 32'd0);
        chk("fl_instr", Instr, 32'h12345678);
        tick;
        chk("fl_stay_idle", 32'(InstrValid), 32'd0);

        // Timeout after 15 REQ cycles without MemReady
        PCin = 32'h30; FetchEn = 1'b1;
        tick;
        FetchEn = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("to_memread", 32'(MemRead), 32'd1);
            chk("to_early", 32'(Timeout), 32'd0);
            tick;
        end
        chk("to_pulse", 32'(Timeout), 32'd1);
        chk("to_memread_off", 32'(MemRead), 32'd0);
        chk("to_busy", 32'(Busy), 32'd0);
        tick;
        chk("to_pulse_end", 32'(Timeout), 32'd0);

        // Misaligned fetch
        PCin = 32'h00000006; FetchEn = 1'b1;
        tick;
        FetchEn = 1'b0;
        chk("mis_pulse", 32'(AddrErr), 32'd1);
        chk("mis_memread", 32'(MemRead), 32'd0);
        chk("mis_busy", 32'(Busy), 32'd0);
        tick;
        chk("mis_pulse_end", 32'(AddrErr), 32'd0);

        // Flush in IDLE suppresses a same-cycle FetchEn
        PCin = 32'h40; FetchEn = 1'b1; Flush = 1'b1;
        tick;
        FetchEn = 1'b0; Flush = 1'b0;
        chk("idle_flush_rd", 32'(MemRead), 32'd0);
        chk("idle_flush_busy", 32'(Busy), 32'd0);

        // Reset during a wait, later MemReady must be ignored
        PCin = 32'h50; FetchEn = 1'b1;
        tick;
        FetchEn = 1'b0;
        tick;
        chk("rr_waiting", 32'(MemRead), 32'd1);
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        chk("rr_memread", 32'(MemRead), 32'd0);
        chk("rr_memaddr", MemAddr, 32'd0);
        chk("rr_busy", 32'(Busy), 32'd0);
        chk("rr_instr", Instr, 32'd0);
        MemReady = 1'b1; MemData = 32'hCAFEF00D;
        tick;
        MemReady = 1'b0;
        chk("rr_no_capture_v", 32'(InstrValid), 32'd0);
        chk("rr_no_capture_i", Instr, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
